encdec_apb_driver: RTL
======================

Name: encdec_apb_driver

Overview:
- APB requester for the EncDec register block; it is the initiator end of the same APB interface.
- Takes one encode/decode job on a start/ready handshake and programs DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL.
- Then waits for operation_done, captures data_out and num_of_errors, and returns one response.
- Sits between the bench/CPU model and the EncDec slave, and also serves as the reusable stimulus engine for the golden-model bench.

Parameters:
- AMBA_ADDR_WIDTH, 20, width of PADDR.
- AMBA_WORD, 32, width of PWDATA, PRDATA and all job register values.
- DATA_WIDTH, 32, width of captured data_out.
- BASE_ADDR, 0, base address of the EncDec register block. Bits [3:0] must be 0.
- TIMEOUT_CYCLES, 1024, maximum WAIT_DONE cycles before the job is aborted.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; accepted when start && ready.
- ready  out  1  high only in IDLE.
- job_ctrl  in  AMBA_WORD  CTRL value.
- job_data_in  in  AMBA_WORD  DATA_IN value.
- job_width  in  AMBA_WORD  CODEWORD_WIDTH value.
- job_noise  in  AMBA_WORD  NOISE value.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PWDATA  out  AMBA_WORD  APB write data.
- PWRITE  out  1  APB direction; always 1 in this block.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PREADY  in  1  APB wait-state input; tie to 1 for APB2 slaves.
- operation_done  in  1  EncDec completion level.
- data_out  in  DATA_WIDTH  EncDec result.
- num_of_errors  in  2  EncDec error count.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  DATA_WIDTH  captured data_out.
- resp_nof  out  2  captured num_of_errors.
- resp_timeout  out  1  qualifies resp_valid; high means the job was aborted.

Behaviour:
- Reset: on rst high, all outputs go to 0 asynchronously except ready, which goes to 1. State returns to IDLE and the job index clears. This also applies mid-transfer: PSEL/PENABLE drop immediately and no partial response is produced.
- Job latch: at acceptance, latch all four job_* values. Later changes on the job_* inputs have no effect until the next job. start while ready=0 is ignored; it is neither queued nor an error.
- Write order and addresses, by index 0..3:
  - 0: DATA_IN at BASE+0x4
  - 1: CODEWORD_WIDTH at BASE+0x8
  - 2: NOISE at BASE+0xC
  - 3: CTRL at BASE+0x0
- CTRL is written last because it launches the operation.
- FSM states: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- IDLE -> SETUP: on accept, index=0.
- SETUP: PSEL=1, PENABLE=0. PADDR, PWDATA and PWRITE are valid here and stay stable through ACCESS. Always exactly one cycle, then -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: hold state and all outputs.
  - PREADY=1, index<3: index++, -> SETUP. There is no idle cycle between back-to-back writes.
  - PREADY=1, index==3: -> WAIT_DONE, PSEL=0, PENABLE=0.
- WAIT_DONE: the timeout counter starts at 0 on entry.
  - operation_done==1 sampled: capture data_out and num_of_errors, resp_timeout=0, -> RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: resp_data=0, resp_nof=0, resp_timeout=1, -> RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. resp_data, resp_nof and resp_timeout hold until the next RESP.
- operation_done outside WAIT_DONE is ignored, including a stale high from a previous job during the writes.
- Latency with PREADY tied to 1: accept at cycle 0; 8 APB cycles; first WAIT_DONE cycle at 9. If done is already high, resp_valid is at cycle 10.
- PADDR[1:0] is always 0, and PADDR[3:2] follows the offset map above. The counter is sized clog2(TIMEOUT_CYCLES) and does not wrap.

Decomposition:
- Package encdec_pkg holds:
  - state enum
  - register offset constants CTRL_OFF=0x0, DATA_IN_OFF=0x4, CW_WIDTH_OFF=0x8, NOISE_OFF=0xC
  - the write-order table index->offset
- One natural sub-module: apb_write_port. It implements the SETUP/ACCESS/PREADY handshake with a req/done interface. The top-level sequencer owns the index, WAIT_DONE and the response logic.

Test Plan:
- Basic job:
  - Stimulus: PREADY=1; job ctrl=1, data_in=0x0000_00A5, width=0, noise=0x01; done is raised 3 cycles after the CTRL write completes, with data_out=0xA5 and nof=1.
  - Response: writes seen at 0x4, 0x8, 0xC, 0x0 with the correct PWDATA; resp_valid occurs once, with resp_data=0xA5, resp_nof=1, resp_timeout=0.
- Wait states:
  - Stimulus: PREADY held low for 2 cycles on every ACCESS.
  - Response: PSEL, PENABLE, PADDR and PWDATA are stable while waiting; the 4 writes complete in 16 cycles total.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, operation_done never asserted.
  - Response: resp_valid exactly 16 cycles after entering WAIT_DONE, with resp_timeout=1 and resp_data=0.
- Stale done and busy start:
  - Stimulus: operation_done held high during the writes; start pulsed while busy.
  - Response: no early response; the second start is ignored; exactly one resp_valid, right after WAIT_DONE is entered.
- Reset mid-transfer:
  - Stimulus: rst asserted while in ACCESS for index 2.
  - Response: PSEL and PENABLE go to 0 asynchronously, ready=1, no resp_valid; a new job afterwards restarts from DATA_IN.

Source files
------------

// File: rtl/encdec_pkg.sv
// Shared types and register map for the EncDec APB requester.
// The write-order table lives here so the sequencer and any bench agree on it.
package encdec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_DONE,
    RESP
  } state_t;

  localparam logic [3:0] CTRL_OFF     = 4'h0;
  localparam logic [3:0] DATA_IN_OFF  = 4'h4;
  localparam logic [3:0] CW_WIDTH_OFF = 4'h8;
  localparam logic [3:0] NOISE_OFF    = 4'hC;

  localparam logic [1:0] LAST_WRITE = 2'd3;

  // CTRL goes last because writing it launches the operation.
  function automatic logic [3:0] write_offset(input logic [1:0] idx);
    case (idx)
      2'd0:    return DATA_IN_OFF;
      2'd1:    return CW_WIDTH_OFF;
      2'd2:    return NOISE_OFF;
      default: return CTRL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/encdec_apb_driver_apb_write_port.sv
// APB write master: one SETUP cycle then ACCESS until PREADY.
// A req sampled on the completing ACCESS cycle chains straight into the next SETUP.
module apb_write_port #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              PREADY,
  output logic              done,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE
);

  assign done = PSEL && PENABLE && PREADY;

  // NOTE: all state below is registered with non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else if (!PSEL || done) begin
      PSEL    <= req;
      PENABLE <= 1'b0;
      if (req) begin
        PADDR  <= addr;
        PWDATA <= wdata;
        PWRITE <= 1'b1;
      end
    end else begin
      PENABLE <= 1'b1;
    end
  end

endmodule

// File: rtl/encdec_apb_driver.sv
// Job sequencer: latches a job, issues four APB writes, waits for completion
// (or timeout) and emits a one-cycle response.
module encdec_apb_driver
  import encdec_pkg::*;
#(
  parameter int                         AMBA_ADDR_WIDTH = 20,
  parameter int                         AMBA_WORD       = 32,
  parameter int                         DATA_WIDTH      = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                         TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       ready,
  input  logic [AMBA_WORD-1:0]       job_ctrl,
  input  logic [AMBA_WORD-1:0]       job_data_in,
  input  logic [AMBA_WORD-1:0]       job_width,
  input  logic [AMBA_WORD-1:0]       job_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PWRITE,
  output logic                       PSEL,
  output logic                       PENABLE,
  input  logic                       PREADY,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic [1:0]                 resp_nof,
  output logic                       resp_timeout
);

  localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                       state;
  logic [1:0]                   index;
  logic [1:0]                   wr_index;
  logic [CNT_W-1:0]             wait_cnt;
  logic [AMBA_WORD-1:0]         ctrl_q, width_q, noise_q;
  logic [AMBA_WORD-1:0]         wr_data;
  logic [AMBA_ADDR_WIDTH-1:0]   wr_addr;
  logic                         wr_req, wr_done;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    wr_req   = 1'b0;
    wr_index = index + 2'd1;
    if (state == IDLE) begin
      wr_req   = start;
      wr_index = 2'd0;
    end else if (state == ACCESS) begin
      wr_req = wr_done && (index != LAST_WRITE);
    end
    case (wr_index)
      2'd0:    wr_data = job_data_in;
      2'd1:    wr_data = width_q;
      2'd2:    wr_data = noise_q;
      default: wr_data = ctrl_q;
    endcase
  end

  assign wr_addr = {BASE_ADDR[AMBA_ADDR_WIDTH-1:4], write_offset(wr_index)};

  apb_write_port #(
    .ADDR_W(AMBA_ADDR_WIDTH),
    .DATA_W(AMBA_WORD)
  ) u_port (
    .clk    (clk),
    .rst    (rst),
    .req    (wr_req),
    .addr   (wr_addr),
    .wdata  (wr_data),
    .PREADY (PREADY),
    .done   (wr_done),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PWRITE (PWRITE),
    .PSEL   (PSEL),
    .PENABLE(PENABLE)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      index        <= '0;
      wait_cnt     <= '0;
      ready        <= 1'b1;
      ctrl_q       <= '0;
      width_q      <= '0;
      noise_q      <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_nof     <= '0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ctrl_q  <= job_ctrl;
          width_q <= job_width;
          noise_q <= job_noise;
          index   <= '0;
          ready   <= 1'b0;
          state   <= SETUP;
        end
        SETUP: state <= ACCESS;
        ACCESS: if (wr_done) begin
          if (index == LAST_WRITE) begin
            wait_cnt <= '0;
            state    <= WAIT_DONE;
          end else begin
            index <= index + 2'd1;
            state <= SETUP;
          end
        end
        WAIT_DONE: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (operation_done) begin
            resp_data    <= data_out;
            resp_nof     <= num_of_errors;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            resp_data    <= '0;
            resp_nof     <= '0;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          ready      <= 1'b1;
          index      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
